// File: rtl/status_flag_unit.sv
// Architectural NZCV flag register with exception save/restore and in-flight flag-writer tracking.
// Flags, SAVED and NEST_ERR update one cycle after the write edge; FLAGS_BUSY trails the counter by one more cycle.
module status_flag_unit #(
    parameter int PEND_MAX = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ALU_N,
    input  logic       ALU_Z,
    input  logic       ALU_C,
    input  logic       ALU_V,
    input  logic       FLAG_WE,
    input  logic       S_BIT,
    input  logic       COND_PASS,
    input  logic       MSR_WE,
    input  logic [3:0] MSR_DATA,
    input  logic       PEND_SET,
    input  logic       EXC_ENTRY,
    input  logic       EXC_RETURN,
    output logic       N,
    output logic       Z,
    output logic       C,
    output logic       V,
    output logic [3:0] SAVED,
    output logic       FLAGS_BUSY,
    output logic       NEST_ERR
);

    localparam logic [2:0] CNT_MAX = 3'(PEND_MAX);

    typedef enum logic {
        NORMAL = 1'b0,
        EXC    = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] saved_q, saved_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q;
    logic       nest_q, nest_d;

    logic       entry_acc;
    logic       return_acc;
    logic       alu_upd;
    logic       retire;

    always_comb begin
        entry_acc  = (state_q == NORMAL) && EXC_ENTRY;
        return_acc = (state_q == EXC) && EXC_RETURN;
        alu_upd    = FLAG_WE && S_BIT && COND_PASS;
        retire     = (FLAG_WE && S_BIT) || MSR_WE;
    end

    // Flag source priority: restore on return, then direct write, then ALU.
    always_comb begin
        flags_d = flags_q;
        if (return_acc) begin
            flags_d = saved_q;
        end else if (MSR_WE) begin
            flags_d = MSR_DATA;
        end else if (alu_upd) begin
            flags_d = {ALU_N, ALU_Z, ALU_C, ALU_V};
        end
    end

    // In EXC a simultaneous return takes precedence, so it is not a nesting error.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        nest_d  = nest_q;
        case (state_q)
            NORMAL: begin
                if (EXC_ENTRY) begin
                    saved_d = flags_q;
                    state_d = EXC;
                end
            end
            EXC: begin
                if (EXC_RETURN) begin
                    state_d = NORMAL;
                end else if (EXC_ENTRY) begin
                    nest_d = 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Accepted exception entry/return flushes the pipeline, so nothing remains in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (entry_acc || return_acc) begin
            cnt_d = 3'd0;
        end else if (PEND_SET && !retire) begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (retire && !PEND_SET) begin
            if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= NORMAL;
            flags_q <= 4'b0000;
            saved_q <= 4'b0000;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            nest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            busy_q  <= (cnt_q != 3'd0);
            nest_q  <= nest_d;
        end
    end

    assign {N, Z, C, V} = flags_q;
    assign SAVED        = saved_q;
    assign FLAGS_BUSY   = busy_q;
    assign NEST_ERR     = nest_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed vector table plus hand-written sequences for status_flag_unit (PEND_MAX=3).
module tb_status_flag_unit;

    logic       CLK;
    logic       RST;
    logic       ALU_N, ALU_Z, ALU_C, ALU_V;
    logic       FLAG_WE, S_BIT, COND_PASS, MSR_WE;
    logic [3:0] MSR_DATA;
    logic       PEND_SET, EXC_ENTRY, EXC_RETURN;
    logic       N, Z, C, V;
    logic [3:0] SAVED;
    logic       FLAGS_BUSY, NEST_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    status_flag_unit #(.PEND_MAX(3)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_N(ALU_N), .ALU_Z(ALU_Z), .ALU_C(ALU_C), .ALU_V(ALU_V),
        .FLAG_WE(FLAG_WE), .S_BIT(S_BIT), .COND_PASS(COND_PASS),
        .MSR_WE(MSR_WE), .MSR_DATA(MSR_DATA), .PEND_SET(PEND_SET),
        .EXC_ENTRY(EXC_ENTRY), .EXC_RETURN(EXC_RETURN),
        .N(N), .Z(Z), .C(C), .V(V), .SAVED(SAVED),
        .FLAGS_BUSY(FLAGS_BUSY), .NEST_ERR(NEST_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] alu;
        logic       fwe, sb, cp, mwe;
        logic [3:0] md;
        logic       ps, ee, er;
        logic [3:0] ef, es;
        logic       eb, en;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] alu, logic fwe, logic sb, logic cp,
                                logic mwe, logic [3:0] md, logic ps, logic ee, logic er,
                                logic [3:0] ef, logic [3:0] es, logic eb, logic en);
        vec_t v;
        v.rst = rst; v.alu = alu; v.fwe = fwe; v.sb = sb; v.cp = cp;
        v.mwe = mwe; v.md = md; v.ps = ps; v.ee = ee; v.er = er;
        v.ef = ef; v.es = es; v.eb = eb; v.en = en;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        RST = v.rst;
        {ALU_N, ALU_Z, ALU_C, ALU_V} = v.alu;
        FLAG_WE = v.fwe; S_BIT = v.sb; COND_PASS = v.cp;
        MSR_WE = v.mwe; MSR_DATA = v.md;
        PEND_SET = v.ps; EXC_ENTRY = v.ee; EXC_RETURN = v.er;
    endtask

    task automatic check_all(string tag, int idx, logic [3:0] ef, logic [3:0] es, logic eb, logic en);
        chk({tag, "_flags"}, idx, {N, Z, C, V}, ef);
        chk({tag, "_saved"}, idx, SAVED, es);
        chk({tag, "_busy"}, idx, {3'b000, FLAGS_BUSY}, {3'b000, eb});
        chk({tag, "_nest"}, idx, {3'b000, NEST_ERR}, {3'b000, en});
    endtask

    initial begin
        vec_t idle;
        idle = mk(1, 4'h0, 0,0,0, 0,4'h0, 0,0,0, 4'h0,4'h0, 0,0);
        drive(idle);
        RST = 1'b0;

        //        rst alu    we s cp msr data  ps ee er  flags  saved  busy nest
        tbl.push_back(mk(0, 4'b0000, 0,0,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 0,0)); // 0 reset
        tbl.push_back(mk(1, 4'b1010, 1,1,1, 0,4'b0000, 0,0,0, 4'b1010,4'b0000, 0,0)); // 1 ALU update
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b0000, 0,0,0, 4'b0000,4'b0000, 0,0)); // 2 MSR clear
        tbl.push_back(mk(1, 4'b1010, 1,1,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 0,0)); // 3 cond fail
        tbl.push_back(mk(1, 4'b1001, 1,1,1, 1,4'b0110, 0,0,0, 4'b0110,4'b0000, 0,0)); // 4 MSR beats ALU
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b1100, 0,0,0, 4'b1100,4'b0000, 0,0)); // 5
        tbl.push_back(mk(1, 4'b0011, 1,1,1, 0,4'b0000, 0,1,0, 4'b0011,4'b1100, 0,0)); // 6 entry + ALU
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b0101, 0,0,1, 4'b1100,4'b1100, 0,0)); // 7 return beats MSR
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,0,1, 4'b1100,4'b1100, 0,0)); // 8 return in NORMAL
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,1,0, 4'b1100,4'b1100, 0,0)); // 9 entry
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b0001, 0,0,0, 4'b0001,4'b1100, 0,0)); // 10 MSR in EXC
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,1,0, 4'b0001,4'b1100, 0,1)); // 11 nested entry
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,1,1, 4'b1100,4'b1100, 0,1)); // 12 both in EXC
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b0111, 0,1,1, 4'b0111,4'b1100, 0,1)); // 13 both in NORMAL
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,1,0, 4'b0111,4'b1100, 0,1)); // 14 nested again
        tbl.push_back(mk(0, 4'b0000, 0,0,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 0,0)); // 15 reset in EXC
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,0,1, 4'b0000,4'b0000, 0,0)); // 16 return ignored
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b0000,4'b0000, 0,0)); // 17 cnt 1
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b0000,4'b0000, 1,0)); // 18 cnt 2
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b0000,4'b0000, 1,0)); // 19 cnt 3
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b0000,4'b0000, 1,0)); // 20 saturate
        tbl.push_back(mk(1, 4'b1111, 1,1,0, 0,4'b0000, 1,0,0, 4'b0000,4'b0000, 1,0)); // 21 inc+retire
        tbl.push_back(mk(1, 4'b1111, 1,1,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 1,0)); // 22 cnt 2
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b0000, 0,0,0, 4'b0000,4'b0000, 1,0)); // 23 cnt 1
        tbl.push_back(mk(1, 4'b1111, 1,1,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 1,0)); // 24 cnt 0
        tbl.push_back(mk(1, 4'b1111, 1,1,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 0,0)); // 25 floor
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 1,4'b1011, 0,0,0, 4'b1011,4'b0000, 0,0)); // 26 floor held
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b1011,4'b0000, 0,0)); // 27 cnt 1
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b1011,4'b0000, 1,0)); // 28 cnt 2
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,1,0, 4'b1011,4'b1011, 1,0)); // 29 entry flush
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b1011,4'b1011, 0,0)); // 30 cnt 1
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,1,0, 4'b1011,4'b1011, 1,1)); // 31 cnt 2, nest
        tbl.push_back(mk(0, 4'b0000, 0,0,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 0,0)); // 32 reset
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,0,1, 4'b0000,4'b0000, 0,0)); // 33 return ignored
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 1,0,0, 4'b0000,4'b0000, 0,0)); // 34 cnt was 0
        tbl.push_back(mk(1, 4'b0000, 0,0,0, 0,4'b0000, 0,0,0, 4'b0000,4'b0000, 1,0)); // 35 cnt 1

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            drive(tbl[i]);
            @(posedge CLK);
            #1;
            check_all("vec", i, tbl[i].ef, tbl[i].es, tbl[i].eb, tbl[i].en);
        end

        // No combinational path from MSR inputs to the flag outputs.
        @(negedge CLK);
        drive(idle);
        MSR_WE = 1'b1; MSR_DATA = 4'b1010;
        #1;
        chk("no_bypass", 0, {N, Z, C, V}, 4'b0000);
        @(posedge CLK);
        #1;
        chk("msr_written", 0, {N, Z, C, V}, 4'b1010);

        // Build EXC state with nesting error and pending count, then reset with all inputs busy.
        @(negedge CLK);
        drive(idle);
        EXC_ENTRY = 1'b1;
        @(negedge CLK);
        drive(idle);
        EXC_ENTRY = 1'b1; PEND_SET = 1'b1;
        @(negedge CLK);
        drive(idle);
        PEND_SET = 1'b1;
        @(posedge CLK);
        #1;
        check_all("pre_rst", 0, 4'b1010, 4'b1010, 1'b1, 1'b1);
        @(negedge CLK);
        drive(idle);
        RST = 1'b0; MSR_WE = 1'b1; MSR_DATA = 4'b1111; EXC_ENTRY = 1'b1;
        EXC_RETURN = 1'b1; PEND_SET = 1'b1; FLAG_WE = 1'b1; S_BIT = 1'b1; COND_PASS = 1'b1;
        {ALU_N, ALU_Z, ALU_C, ALU_V} = 4'b1111;
        @(posedge CLK);
        #1;
        check_all("rst_prec", 0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge CLK);
        drive(idle);
        @(posedge CLK);
        #1;
        check_all("post_rst", 0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
